// File: rtl/rr_tdm_demux_if.sv
// rr_tdm_demux_if: TDM demux bus; master drives in/sync, slave returns frame outputs, frame_valid, locked, sync_err, frame_cnt
interface rr_tdm_demux_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0] in;
    logic             sync;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] c_out;
    logic [WIDTH-1:0] d_out;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;
    logic [7:0]       frame_cnt;
    modport master (
        output in, sync,
        input  a_out, b_out, c_out, d_out, frame_valid, locked, sync_err, frame_cnt
    );
    modport slave (
        input  in, sync,
        output a_out, b_out, c_out, d_out, frame_valid, locked, sync_err, frame_cnt
    );
endinterface

// File: rtl/rr_tdm_demux.sv
// rr_tdm_demux: 4-slot round-robin TDM demux; ports clk, rst, bus (in/sync in; a..d_out, frame_valid, locked, sync_err, frame_cnt out)
module rr_tdm_demux #(
    parameter int WIDTH = 1
) (
    input logic           clk,
    input logic           rst,
    rr_tdm_demux_if.slave bus
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t           state;
    logic [1:0]       s;
    logic [1:0]       e;
    logic             proc;
    logic [WIDTH-1:0] shadow_a;
    logic [WIDTH-1:0] shadow_b;
    logic [WIDTH-1:0] shadow_c;
    always_comb begin
        e    = bus.sync ? 2'd0 : s;
        proc = (state == LOCKED) || bus.sync;
    end
    assign bus.locked = (state == LOCKED);
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= UNLOCKED;
            s               <= 2'd0;
            shadow_a        <= '0;
            shadow_b        <= '0;
            shadow_c        <= '0;
            bus.a_out       <= '0;
            bus.b_out       <= '0;
            bus.c_out       <= '0;
            bus.d_out       <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
            bus.frame_cnt   <= 8'd0;
        end else begin
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= bus.sync && (state == LOCKED) && (s != 2'd0);
            if (proc) begin
                state <= LOCKED;
                s     <= e + 2'd1;
                if (e == 2'd0) begin
                    shadow_a <= bus.in;
                    shadow_b <= '0;
                    shadow_c <= '0;
                end else if (e == 2'd1) begin
                    shadow_b <= bus.in;
                end else if (e == 2'd2) begin
                    shadow_c <= bus.in;
                end else begin
                    bus.a_out       <= shadow_a;
                    bus.b_out       <= shadow_b;
                    bus.c_out       <= shadow_c;
                    bus.d_out       <= bus.in;
                    bus.frame_valid <= 1'b1;
                    bus.frame_cnt   <= bus.frame_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_tdm_demux.sv
// tb_rr_tdm_demux: directed table-driven and sequence checks for rr_tdm_demux
module tb_rr_tdm_demux;
    typedef struct {
        logic       rst;
        logic       sync;
        logic       in;
        logic [3:0] abcd;
        logic       fv;
        logic       lk;
        logic       se;
        logic [7:0] cnt;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    rr_tdm_demux_if #(.WIDTH(1)) bus ();
    rr_tdm_demux #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic vec_t v(logic r, logic sy, logic i, logic [3:0] o, logic fv, logic lk, logic se, logic [7:0] c);
        vec_t x;
        x.rst = r; x.sync = sy; x.in = i; x.abcd = o; x.fv = fv; x.lk = lk; x.se = se; x.cnt = c;
        return x;
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step(input logic r, input logic sy, input logic i);
        rst      = r;
        bus.sync = sy;
        bus.in   = i;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [3:0] outs();
        return {bus.a_out, bus.b_out, bus.c_out, bus.d_out};
    endfunction
    initial begin
        bus.in   = 1'b0;
        bus.sync = 1'b0;
        // reset, lock and first frame 1,0,1,1
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 4'b1011, 1, 1, 0, 1));
        // free-running frames 1100, 0011, 1001
        vecs.push_back(v(0, 0, 1, 4'b1011, 0, 1, 0, 1));
        vecs.push_back(v(0, 0, 1, 4'b1011, 0, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 4'b1011, 0, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 4'b1100, 1, 1, 0, 2));
        vecs.push_back(v(0, 0, 0, 4'b1100, 0, 1, 0, 2));
        vecs.push_back(v(0, 0, 0, 4'b1100, 0, 1, 0, 2));
        vecs.push_back(v(0, 0, 1, 4'b1100, 0, 1, 0, 2));
        vecs.push_back(v(0, 0, 1, 4'b0011, 1, 1, 0, 3));
        vecs.push_back(v(0, 0, 1, 4'b0011, 0, 1, 0, 3));
        vecs.push_back(v(0, 0, 0, 4'b0011, 0, 1, 0, 3));
        vecs.push_back(v(0, 0, 0, 4'b0011, 0, 1, 0, 3));
        vecs.push_back(v(0, 0, 1, 4'b1001, 1, 1, 0, 4));
        // realign at s=2: aborted frame, then 1111
        vecs.push_back(v(0, 0, 0, 4'b1001, 0, 1, 0, 4));
        vecs.push_back(v(0, 0, 0, 4'b1001, 0, 1, 0, 4));
        vecs.push_back(v(0, 1, 1, 4'b1001, 0, 1, 1, 4));
        vecs.push_back(v(0, 0, 1, 4'b1001, 0, 1, 0, 4));
        vecs.push_back(v(0, 0, 1, 4'b1001, 0, 1, 0, 4));
        vecs.push_back(v(0, 0, 1, 4'b1111, 1, 1, 0, 5));
        // aligned sync at s=0: no error
        vecs.push_back(v(0, 1, 0, 4'b1111, 0, 1, 0, 5));
        vecs.push_back(v(0, 0, 1, 4'b1111, 0, 1, 0, 5));
        vecs.push_back(v(0, 0, 0, 4'b1111, 0, 1, 0, 5));
        vecs.push_back(v(0, 0, 1, 4'b0101, 1, 1, 0, 6));
        // back-to-back sync: second raises sync_err and clears shadows
        vecs.push_back(v(0, 1, 0, 4'b0101, 0, 1, 0, 6));
        vecs.push_back(v(0, 0, 1, 4'b0101, 0, 1, 0, 6));
        vecs.push_back(v(0, 1, 1, 4'b0101, 0, 1, 1, 6));
        vecs.push_back(v(0, 0, 0, 4'b0101, 0, 1, 0, 6));
        vecs.push_back(v(0, 0, 0, 4'b0101, 0, 1, 0, 6));
        vecs.push_back(v(0, 0, 1, 4'b1001, 1, 1, 0, 7));
        // reset mid-frame at s=2, ignore in until sync, fresh frame 0110
        vecs.push_back(v(0, 1, 1, 4'b1001, 0, 1, 0, 7));
        vecs.push_back(v(0, 0, 1, 4'b1001, 0, 1, 0, 7));
        vecs.push_back(v(1, 1, 1, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 4'b0110, 1, 1, 0, 1));
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].rst, vecs[k].sync, vecs[k].in);
            check($sformatf("v%0d_outs", k), 32'(outs()), 32'(vecs[k].abcd));
            check($sformatf("v%0d_frame_valid", k), 32'(bus.frame_valid), 32'(vecs[k].fv));
            check($sformatf("v%0d_locked", k), 32'(bus.locked), 32'(vecs[k].lk));
            check($sformatf("v%0d_sync_err", k), 32'(bus.sync_err), 32'(vecs[k].se));
            check($sformatf("v%0d_frame_cnt", k), 32'(bus.frame_cnt), 32'(vecs[k].cnt));
        end
        // no sync after reset: everything stays 0 regardless of in
        step(1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 1'($urandom));
            check($sformatf("idle%0d", k),
                  32'({outs(), bus.frame_valid, bus.locked, bus.sync_err, bus.frame_cnt}), 32'd0);
        end
        // 256 aligned frames: frame_cnt wraps to 0 with frame_valid still high
        step(1, 0, 0);
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] fb;
                fb = 8'(f);
                step(0, (f == 0) && (k == 0), fb[k]);
            end
            begin
                logic [7:0] fb;
                logic [7:0] ec;
                fb = 8'(f);
                ec = 8'(f + 1);
                check($sformatf("wrap%0d_fv", f), 32'(bus.frame_valid), 32'd1);
                check($sformatf("wrap%0d_cnt", f), 32'(bus.frame_cnt), 32'(ec));
                check($sformatf("wrap%0d_outs", f), 32'(outs()), 32'({fb[0], fb[1], fb[2], fb[3]}));
            end
        end
        step(0, 0, 0);
        check("post_wrap_fv", 32'(bus.frame_valid), 32'd0);
        check("post_wrap_cnt", 32'(bus.frame_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
